// File: rtl/key_action_if.sv
// Key action bundle: debounced key levels and enable in, per-key strobes and held levels out.
interface key_action_if #(
    parameter int KEY_CNT = 8
);
    logic [KEY_CNT-1:0] keys_stable;
    logic               en;
    logic [KEY_CNT-1:0] key_pulse;
    logic [KEY_CNT-1:0] key_held;
    logic               any_press;

    modport master (
        output keys_stable, en,
        input  key_pulse, key_held, any_press
    );

    modport slave (
        input  keys_stable, en,
        output key_pulse, key_held, any_press
    );
endinterface

// File: rtl/key_action_gen.sv
// Per-key press/auto-repeat action generator: one strobe on press, then optional
// auto-repeat after a hold delay; keys are fully independent of each other.
module key_action_gen #(
    parameter int               CLK_FREQ    = 50_000_000,
    parameter int               KEY_CNT     = 8,
    parameter int               DELAY_MS    = 200,
    parameter int               REPEAT_MS   = 50,
    parameter logic [KEY_CNT-1:0] REPEAT_MASK = 8'b0000_0111
) (
    input  logic           clk,
    input  logic           rst,
    key_action_if.slave    bus
);
    localparam int DELAY_RAW  = CLK_FREQ / 1000 * DELAY_MS;
    localparam int REPEAT_RAW = CLK_FREQ / 1000 * REPEAT_MS;
    // Terminal counts; a zero-length period degenerates to one cycle.
    localparam logic [31:0] DELAY_LAST  = (DELAY_RAW  < 1) ? 32'd0 : 32'(DELAY_RAW  - 1);
    localparam logic [31:0] REPEAT_LAST = (REPEAT_RAW < 1) ? 32'd0 : 32'(REPEAT_RAW - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REPEAT,
        HELD
    } key_state_e;

    key_state_e         state_q [KEY_CNT];
    key_state_e         state_d [KEY_CNT];
    logic [31:0]        cnt_q   [KEY_CNT];
    logic [31:0]        cnt_d   [KEY_CNT];
    logic [KEY_CNT-1:0] prev_keys;
    logic [KEY_CNT-1:0] pulse_d;
    logic [KEY_CNT-1:0] key_pulse_q;
    logic [KEY_CNT-1:0] key_held_q;

    // NOTE: every variable gets its default before the case, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < KEY_CNT; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (prev_keys[i] && !bus.keys_stable[i]) begin
                        state_d[i] = WAIT;
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end
                end
                WAIT: begin
                    // Release is checked first so it beats a coincident terminal count.
                    if (bus.keys_stable[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DELAY_LAST) begin
                        if (REPEAT_MASK[i]) begin
                            state_d[i] = REPEAT;
                            cnt_d[i]   = '0;
                            pulse_d[i] = 1'b1;
                        end else begin
                            state_d[i] = HELD;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                REPEAT: begin
                    if (bus.keys_stable[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == REPEAT_LAST) begin
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                HELD: begin
                    if (bus.keys_stable[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // NOTE: the per-key state and counter arrays are small control registers, so
    // they are reset explicitly like any other flop rather than left to RAM rules.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_CNT; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_CNT; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Reset value of all ones lets a key held through reset count as a fresh press.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_keys   <= '1;
            key_pulse_q <= '0;
            key_held_q  <= '0;
        end else begin
            prev_keys   <= bus.keys_stable;
            key_pulse_q <= pulse_d & {KEY_CNT{bus.en}};
            key_held_q  <= ~bus.keys_stable;
        end
    end

    assign bus.key_pulse = key_pulse_q;
    assign bus.key_held  = key_held_q;
    assign bus.any_press = |key_pulse_q;
endmodule

// File: tb/tb_key_action_gen.sv
// Directed bench for key_action_gen with DELAY_CYC=4 and REPEAT_CYC=2.
module tb_key_action_gen;
    localparam int KEY_CNT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    key_action_if #(.KEY_CNT(KEY_CNT)) bus ();

    key_action_gen #(
        .CLK_FREQ   (1000),
        .KEY_CNT    (KEY_CNT),
        .DELAY_MS   (4),
        .REPEAT_MS  (2),
        .REPEAT_MASK(8'b0000_0111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.keys_stable = '1;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [31:0] trace;
    logic [31:0] any_trace;
    int          held_cnt;

    initial begin
        bus.keys_stable = '1;
        bus.en          = 1'b1;
        #12;
        check("rst_pulse", 32'(bus.key_pulse), 32'h0);
        check("rst_held",  32'(bus.key_held),  32'h0);
        check("rst_any",   32'(bus.any_press), 32'h0);
        step();
        rst = 1'b0;
        idle(2);

        // Tap on key0: three cycles low.
        bus.keys_stable = 8'hFE;
        step();
        check("tap_pulse1", 32'(bus.key_pulse), 32'h01);
        check("tap_any1",   32'(bus.any_press), 32'h1);
        check("tap_held1",  32'(bus.key_held),  32'h01);
        step();
        check("tap_pulse2", 32'(bus.key_pulse), 32'h00);
        step();
        check("tap_held3",  32'(bus.key_held),  32'h01);
        bus.keys_stable = 8'hFF;
        trace = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            trace[k] = bus.any_press;
        end
        check("tap_no_more", trace, 32'h0);
        check("tap_released", 32'(bus.key_held), 32'h00);

        // Hold key1 for 12 sampled cycles: pulses at steps 1,5,7,9,11.
        bus.keys_stable = 8'hFD;
        trace = '0;
        any_trace = '0;
        for (int k = 1; k <= 18; k++) begin
            step();
            trace[k]     = bus.key_pulse[1];
            any_trace[k] = bus.any_press;
            if (k == 12) bus.keys_stable = 8'hFF;
        end
        check("rep_trace", trace, 32'h0000_0AA2);
        check("rep_any",   any_trace, 32'h0000_0AA2);
        idle(2);

        // Key5 does not repeat: one pulse over a 20-cycle hold.
        bus.keys_stable = 8'hDF;
        trace = '0;
        held_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            trace[k] = bus.key_pulse[5];
            if (bus.key_held == 8'h20) held_cnt++;
        end
        check("norep_trace", trace, 32'h0000_0002);
        check("norep_held",  32'(held_cnt), 32'd20);
        bus.keys_stable = 8'hFF;
        step();
        check("norep_release", 32'(bus.key_held), 32'h00);
        idle(2);

        // Key0 and key2 together; key0 released exactly on its terminal count.
        bus.keys_stable = 8'hFA;
        step();
        check("simul_pulse", 32'(bus.key_pulse), 32'h05);
        for (int k = 2; k <= 4; k++) step();
        bus.keys_stable = 8'hFB;
        step();
        check("tc_release", 32'(bus.key_pulse), 32'h04);
        check("tc_held",    32'(bus.key_held),  32'h04);
        idle(3);

        // Key1 with en low for the first six cycles, then raised mid-hold.
        bus.en = 1'b0;
        bus.keys_stable = 8'hFD;
        trace = '0;
        for (int k = 1; k <= 11; k++) begin
            step();
            trace[k] = bus.key_pulse[1];
            if (k == 3) check("en_held", 32'(bus.key_held), 32'h02);
            if (k == 6) bus.en = 1'b1;
        end
        check("en_trace", trace, 32'h0000_0A80);

        // Reset mid-repeat, right after a pulse.
        rst = 1'b1;
        #1;
        check("mid_rst_pulse", 32'(bus.key_pulse), 32'h0);
        check("mid_rst_held",  32'(bus.key_held),  32'h0);
        check("mid_rst_any",   32'(bus.any_press), 32'h0);
        step();
        step();
        check("in_rst_pulse", 32'(bus.key_pulse), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_pulse", 32'(bus.key_pulse), 32'h02);
        step();
        check("post_rst_quiet", 32'(bus.key_pulse), 32'h00);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
